// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths and the reorder-buffer entry layout.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_ID_W  = 5;
  localparam int ROB_TAG_W = 5;
  localparam int ROB_DEPTH = 32;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                is_branch;
    logic                pred_taken;
    logic                taken;
    logic [REG_ID_W-1:0] rd;
    logic [XLEN-1:0]     val;
    logic [XLEN-1:0]     alt_pc;
  } rob_entry_t;

  function automatic logic mispredicted(rob_entry_t e);
    return e.is_branch && (e.taken != e.pred_taken);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, query, commit and flush signals of the reorder buffer.
interface reorder_buffer_if;
  import cpu_pkg::*;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [REG_ID_W-1:0]  issue_rd;
  logic                 issue_is_branch;
  logic                 issue_pred_taken;
  logic [XLEN-1:0]      issue_alt_pc;
  logic [ROB_TAG_W-1:0] issue_tag;

  logic                 dependency_set_en;
  logic [REG_ID_W-1:0]  dependency_reg;
  logic [ROB_TAG_W-1:0] dependency_dependency;

  logic                 cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]      cdb_val;
  logic                 cdb_taken;

  logic [ROB_TAG_W-1:0] query1_tag;
  logic [ROB_TAG_W-1:0] query2_tag;
  logic                 query1_ready;
  logic                 query2_ready;
  logic [XLEN-1:0]      query1_val;
  logic [XLEN-1:0]      query2_val;

  logic                 write_en;
  logic [REG_ID_W-1:0]  write_id;
  logic [XLEN-1:0]      write_val;
  logic [ROB_TAG_W-1:0] write_dependency;

  logic                 dependency_rst;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic [ROB_TAG_W:0]   count;

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output cdb_valid, cdb_tag, cdb_val, cdb_taken, query1_tag, query2_tag,
    input  issue_ready, issue_tag, dependency_set_en, dependency_reg, dependency_dependency,
    input  query1_ready, query2_ready, query1_val, query2_val,
    input  write_en, write_id, write_val, write_dependency,
    input  dependency_rst, redirect_valid, redirect_pc, count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  cdb_valid, cdb_tag, cdb_val, cdb_taken, query1_tag, query2_tag,
    output issue_ready, issue_tag, dependency_set_en, dependency_reg, dependency_dependency,
    output query1_ready, query2_ready, query1_val, query2_val,
    output write_en, write_id, write_val, write_dependency,
    output dependency_rst, redirect_valid, redirect_pc, count
  );

endinterface

// File: rtl/reorder_buffer_rob_storage.sv
// Reorder-buffer entry array: allocate, CDB and retire write ports,
// head and two query read ports, and a flush that drops every entry.
module rob_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_en,
  input  logic [TAG_W-1:0]    alloc_idx,
  input  logic [REG_ID_W-1:0] alloc_rd,
  input  logic                alloc_is_branch,
  input  logic                alloc_pred_taken,
  input  logic [XLEN-1:0]     alloc_alt_pc,
  input  logic                cdb_en,
  input  logic [TAG_W-1:0]    cdb_idx,
  input  logic [XLEN-1:0]     cdb_val,
  input  logic                cdb_taken,
  input  logic                retire_en,
  input  logic [TAG_W-1:0]    retire_idx,
  input  logic [TAG_W-1:0]    head_idx,
  output rob_entry_t          head_entry,
  input  logic [TAG_W-1:0]    q1_idx,
  output logic                q1_busy,
  output logic                q1_done,
  output logic [XLEN-1:0]     q1_val,
  input  logic [TAG_W-1:0]    q2_idx,
  output logic                q2_busy,
  output logic                q2_done,
  output logic [XLEN-1:0]     q2_val
);

  rob_entry_t mem [DEPTH];

  // Allocation leaves val untouched, so a query on a fresh tag still
  // returns the last value that slot captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].busy <= 1'b0;
        mem[i].done <= 1'b0;
      end
    end else begin
      if (cdb_en && mem[cdb_idx].busy) begin
        mem[cdb_idx].done  <= 1'b1;
        mem[cdb_idx].val   <= cdb_val;
        mem[cdb_idx].taken <= cdb_taken;
      end
      if (alloc_en) begin
        mem[alloc_idx].busy       <= 1'b1;
        mem[alloc_idx].done       <= 1'b0;
        mem[alloc_idx].rd         <= alloc_rd;
        mem[alloc_idx].is_branch  <= alloc_is_branch;
        mem[alloc_idx].pred_taken <= alloc_pred_taken;
        mem[alloc_idx].alt_pc     <= alloc_alt_pc;
      end
      if (retire_en) begin
        mem[retire_idx].busy <= 1'b0;
        mem[retire_idx].done <= 1'b0;
      end
    end
  end

  assign head_entry = mem[head_idx];
  assign q1_busy    = mem[q1_idx].busy;
  assign q1_done    = mem[q1_idx].done;
  assign q1_val     = mem[q1_idx].val;
  assign q2_busy    = mem[q2_idx].busy;
  assign q2_done    = mem[q2_idx].done;
  assign q2_val     = mem[q2_idx].val;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit unit: tag allocation, rename, CDB capture, commit and
// mispredict flush. Define ROB_CDB_BYPASS_EN to forward CDB results to queries.
module reorder_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);

  localparam logic [TAG_W:0] FULL = DEPTH[TAG_W:0];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;
  rob_entry_t       head_e;
  logic             q1_busy, q1_done, q2_busy, q2_done;
  logic [XLEN-1:0]  q1_val, q2_val;
  logic             commit, flush, ready, accept, write_en, set_en;

  // Commit sees only registered entry state, never the live CDB.
  always_comb begin
    commit   = !rst && head_e.busy && head_e.done;
    flush    = commit && mispredicted(head_e);
    ready    = !rst && (count_q != FULL) && !flush;
    accept   = rob.issue_valid && ready;
    set_en   = accept && (rob.issue_rd != '0);
    write_en = commit && !head_e.is_branch && (head_e.rd != '0);
  end

  rob_storage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_storage (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .alloc_en         (accept),
    .alloc_idx        (tail_q),
    .alloc_rd         (rob.issue_rd),
    .alloc_is_branch  (rob.issue_is_branch),
    .alloc_pred_taken (rob.issue_pred_taken),
    .alloc_alt_pc     (rob.issue_alt_pc),
    .cdb_en           (rob.cdb_valid),
    .cdb_idx          (rob.cdb_tag),
    .cdb_val          (rob.cdb_val),
    .cdb_taken        (rob.cdb_taken),
    .retire_en        (commit),
    .retire_idx       (head_q),
    .head_idx         (head_q),
    .head_entry       (head_e),
    .q1_idx           (rob.query1_tag),
    .q1_busy          (q1_busy),
    .q1_done          (q1_done),
    .q1_val           (q1_val),
    .q2_idx           (rob.query2_tag),
    .q2_busy          (q2_busy),
    .q2_done          (q2_done),
    .q2_val           (q2_val)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) tail_q <= tail_q + 1'b1;
      if (commit) head_q <= head_q + 1'b1;
      if (accept && !commit)      count_q <= count_q + 1'b1;
      else if (!accept && commit) count_q <= count_q - 1'b1;
    end
  end

  assign rob.issue_ready           = ready;
  assign rob.issue_tag             = rst ? '0 : tail_q;
  assign rob.dependency_set_en     = set_en;
  assign rob.dependency_reg        = set_en ? rob.issue_rd : '0;
  assign rob.dependency_dependency = set_en ? tail_q : '0;
  assign rob.write_en              = write_en;
  assign rob.write_id              = write_en ? head_e.rd : '0;
  assign rob.write_val             = write_en ? head_e.val : '0;
  assign rob.write_dependency      = write_en ? head_q : '0;
  assign rob.dependency_rst        = flush;
  assign rob.redirect_valid        = flush;
  assign rob.redirect_pc           = flush ? head_e.alt_pc : '0;
  assign rob.count                 = rst ? '0 : count_q;

`ifdef ROB_CDB_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = rob.cdb_valid && (rob.cdb_tag == rob.query1_tag) && q1_busy;
  assign hit2 = rob.cdb_valid && (rob.cdb_tag == rob.query2_tag) && q2_busy;
  assign rob.query1_ready = !rst && q1_busy && (q1_done || hit1);
  assign rob.query2_ready = !rst && q2_busy && (q2_done || hit2);
  assign rob.query1_val   = rst ? '0 : (hit1 ? rob.cdb_val : q1_val);
  assign rob.query2_val   = rst ? '0 : (hit2 ? rob.cdb_val : q2_val);
`else
  assign rob.query1_ready = !rst && q1_busy && q1_done;
  assign rob.query2_ready = !rst && q2_busy && q2_done;
  assign rob.query1_val   = rst ? '0 : q1_val;
  assign rob.query2_val   = rst ? '0 : q2_val;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder-buffer bench: directed scenarios then random traffic, all
// checked against an in-order queue model of the buffer.
module tb_reorder_buffer;
  import cpu_pkg::*;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if bus ();
  reorder_buffer dut (.clk(clk), .rst(rst), .rob(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          br;
    bit          pred;
    bit          done;
    bit          taken;
    logic [31:0] val;
    logic [31:0] alt;
  } ent_t;

  ent_t        q[$];
  int          next_tag;
  logic [31:0] last_val [32];

  bit          e_accept, e_commit, e_flush;
  logic [31:0] e_ready, e_tag, e_set, e_reg, e_dep, e_wen, e_wid, e_wval, e_wdep;
  logic [31:0] e_pc, e_count, e_q1r, e_q1v, e_q2r, e_q2v;

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int find(int tag);
    for (int k = 0; k < q.size(); k++) if (q[k].tag == tag) return k;
    return -1;
  endfunction

  function automatic void qeval(input logic [4:0] t, output logic [31:0] r, output logic [31:0] v);
    int k;
    k = find(int'(t));
    r = 32'((k >= 0) && q[k].done);
    v = last_val[t];
    if (BYP && k >= 0 && bus.cdb_valid && bus.cdb_tag == t) begin
      r = 32'd1;
      v = bus.cdb_val;
    end
  endfunction

  task automatic model_eval();
    {e_ready, e_tag, e_set, e_reg, e_dep, e_wen, e_wid, e_wval, e_wdep} = '0;
    {e_pc, e_count, e_q1r, e_q1v, e_q2r, e_q2v} = '0;
    e_accept = 0; e_commit = 0; e_flush = 0;
    if (!rst) begin
      e_commit = q.size() > 0 && q[0].done;
      e_flush  = e_commit && q[0].br && (q[0].taken != q[0].pred);
      e_ready  = 32'(q.size() < 32 && !e_flush);
      e_accept = bus.issue_valid && e_ready[0];
      e_tag    = 32'(next_tag);
      e_set    = 32'(e_accept && bus.issue_rd != 0);
      e_reg    = e_set[0] ? 32'(bus.issue_rd) : 32'd0;
      e_dep    = e_set[0] ? 32'(next_tag) : 32'd0;
      if (e_commit && !q[0].br && q[0].rd != 0) begin
        e_wen  = 32'd1;
        e_wid  = 32'(q[0].rd);
        e_wval = q[0].val;
        e_wdep = 32'(q[0].tag);
      end
      e_pc    = e_flush ? q[0].alt : 32'd0;
      e_count = 32'(q.size());
      qeval(bus.query1_tag, e_q1r, e_q1v);
      qeval(bus.query2_tag, e_q2r, e_q2v);
    end
  endtask

  task automatic model_update();
    int k;
    ent_t n;
    if (rst) begin
      q.delete();
      next_tag = 0;
      for (int i = 0; i < 32; i++) last_val[i] = '0;
    end else if (e_flush) begin
      q.delete();
      next_tag = 0;
    end else begin
      if (bus.cdb_valid) begin
        k = find(int'(bus.cdb_tag));
        if (k >= 0) begin
          q[k].done  = 1;
          q[k].val   = bus.cdb_val;
          q[k].taken = bus.cdb_taken;
          last_val[bus.cdb_tag] = bus.cdb_val;
        end
      end
      if (e_commit) void'(q.pop_front());
      if (e_accept) begin
        n.tag = next_tag; n.rd = bus.issue_rd; n.br = bus.issue_is_branch;
        n.pred = bus.issue_pred_taken; n.done = 0; n.taken = 0;
        n.val = '0; n.alt = bus.issue_alt_pc;
        q.push_back(n);
        next_tag = (next_tag + 1) % 32;
      end
    end
  endtask

  // One clock: compare every output with the model, clock, advance the model.
  task automatic cyc();
    #1;
    model_eval();
    chk("issue_ready", 32'(bus.issue_ready), e_ready);
    chk("issue_tag", 32'(bus.issue_tag), e_tag);
    chk("dep_set_en", 32'(bus.dependency_set_en), e_set);
    chk("dep_reg", 32'(bus.dependency_reg), e_reg);
    chk("dep_dep", 32'(bus.dependency_dependency), e_dep);
    chk("write_en", 32'(bus.write_en), e_wen);
    chk("write_id", 32'(bus.write_id), e_wid);
    chk("write_val", bus.write_val, e_wval);
    chk("write_dep", 32'(bus.write_dependency), e_wdep);
    chk("dep_rst", 32'(bus.dependency_rst), 32'(e_flush));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_flush));
    chk("redirect_pc", bus.redirect_pc, e_pc);
    chk("count", 32'(bus.count), e_count);
    chk("q1_ready", 32'(bus.query1_ready), e_q1r);
    chk("q1_val", bus.query1_val, e_q1v);
    chk("q2_ready", 32'(bus.query2_ready), e_q2r);
    chk("q2_val", bus.query2_val, e_q2v);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_is_branch = 0;
    bus.issue_pred_taken = 0; bus.issue_alt_pc = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_val = '0; bus.cdb_taken = 0;
  endtask

  task automatic issue(logic [4:0] rd, bit br, bit pred, logic [31:0] alt);
    bus.issue_valid = 1; bus.issue_rd = rd; bus.issue_is_branch = br;
    bus.issue_pred_taken = pred; bus.issue_alt_pc = alt;
  endtask

  task automatic cdb(logic [4:0] tag, logic [31:0] val, bit taken);
    bus.cdb_valid = 1; bus.cdb_tag = tag; bus.cdb_val = val; bus.cdb_taken = taken;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    int pct;
    int k;
    for (int i = 0; i < 32; i++) last_val[i] = '0;
    next_tag = 0;
    bus.query1_tag = '0; bus.query2_tag = '0;
    idle();
    rst = 1;
    cyc();
    do_reset();

    // Reset state and single issue -> CDB -> commit
    #1;
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    issue(5'd3, 0, 0, '0);
    #1;
    chk("t1_set_en", 32'(bus.dependency_set_en), 32'd1);
    chk("t1_dep_reg", 32'(bus.dependency_reg), 32'd3);
    chk("t1_dep_tag", 32'(bus.dependency_dependency), 32'd0);
    cyc();
    idle(); cdb(5'd0, 32'hDEADBEEF, 0);
    #1 chk("t1_no_early_commit", 32'(bus.write_en), 32'd0);
    cyc();
    idle();
    #1;
    chk("t1_write_en", 32'(bus.write_en), 32'd1);
    chk("t1_write_id", 32'(bus.write_id), 32'd3);
    chk("t1_write_val", bus.write_val, 32'hDEADBEEF);
    chk("t1_write_dep", 32'(bus.write_dependency), 32'd0);
    cyc();

    // Out-of-order completion commits in order
    do_reset();
    issue(5'd5, 0, 0, '0); cyc();
    issue(5'd6, 0, 0, '0); cyc();
    idle(); cdb(5'd1, 32'h11, 0); cyc();
    idle(); cdb(5'd0, 32'h22, 0);
    #1 chk("t2_tag1_not_first", 32'(bus.write_en), 32'd0);
    cyc();
    idle();
    #1;
    chk("t2_first_en", 32'(bus.write_en), 32'd1);
    chk("t2_first_dep", 32'(bus.write_dependency), 32'd0);
    cyc();
    #1;
    chk("t2_second_en", 32'(bus.write_en), 32'd1);
    chk("t2_second_dep", 32'(bus.write_dependency), 32'd1);
    chk("t2_second_val", bus.write_val, 32'h11);
    cyc();

    // Fill to 32, tag wrap, then drain one
    do_reset();
    for (int i = 0; i < 32; i++) begin
      issue(5'(i % 31 + 1), 0, 0, '0);
      #1 chk("t3_fill_tag", 32'(bus.issue_tag), 32'(i));
      cyc();
    end
    cdb(5'd0, 32'h77, 0);
    #1;
    chk("t3_full_count", 32'(bus.count), 32'd32);
    chk("t3_full_ready", 32'(bus.issue_ready), 32'd0);
    chk("t3_wrap_tag", 32'(bus.issue_tag), 32'd0);
    chk("t3_full_no_set", 32'(bus.dependency_set_en), 32'd0);
    cyc();
    bus.cdb_valid = 0; bus.issue_rd = 5'd9;
    #1;
    chk("t3_commit_en", 32'(bus.write_en), 32'd1);
    chk("t3_commit_val", bus.write_val, 32'h77);
    chk("t3_no_same_cycle_reuse", 32'(bus.issue_ready), 32'd0);
    cyc();
    #1;
    chk("t3_ready_again", 32'(bus.issue_ready), 32'd1);
    chk("t3_new_set", 32'(bus.dependency_set_en), 32'd1);
    chk("t3_new_tag", 32'(bus.dependency_dependency), 32'd0);
    cyc();
    idle();

    // Mispredicted branch at tag 2
    do_reset();
    issue(5'd1, 0, 0, '0); cyc();
    issue(5'd2, 0, 0, '0); cyc();
    issue(5'd0, 1, 0, 32'h100); cyc();
    idle(); cdb(5'd0, 32'hA0, 0); cyc();
    idle(); cdb(5'd1, 32'hA1, 0); cyc();
    idle(); cdb(5'd2, 32'h0, 1); cyc();
    idle(); issue(5'd7, 0, 0, '0);
    #1;
    chk("t4_dep_rst", 32'(bus.dependency_rst), 32'd1);
    chk("t4_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("t4_redirect_pc", bus.redirect_pc, 32'h100);
    chk("t4_no_write", 32'(bus.write_en), 32'd0);
    chk("t4_issue_blocked", 32'(bus.dependency_set_en), 32'd0);
    cyc();
    #1;
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_dep_rst_1cyc", 32'(bus.dependency_rst), 32'd0);
    chk("t4_tag0", 32'(bus.dependency_dependency), 32'd0);
    chk("t4_accept", 32'(bus.dependency_set_en), 32'd1);
    cyc();
    idle();

    // Query while CDB for the same tag is on the bus
    do_reset();
    for (int i = 0; i < 5; i++) begin issue(5'(i + 1), 0, 0, '0); cyc(); end
    idle(); cdb(5'd4, 32'h55, 0);
    bus.query1_tag = 5'd4; bus.query2_tag = 5'd3;
    #1;
    chk("t5_q1_ready_same", 32'(bus.query1_ready), 32'(BYP));
    chk("t5_q1_val_same", bus.query1_val, BYP ? 32'h55 : 32'h0);
    chk("t5_q2_not_ready", 32'(bus.query2_ready), 32'd0);
    cyc();
    idle();
    #1;
    chk("t5_q1_ready_next", 32'(bus.query1_ready), 32'd1);
    chk("t5_q1_val_next", bus.query1_val, 32'h55);
    cyc();

    // Reset with 5 entries in flight
    rst = 1; issue(5'd3, 0, 0, '0); cdb(5'd0, 32'h99, 0);
    #1 chk("t6_rst_no_write", 32'(bus.write_en), 32'd0);
    cyc();
    rst = 0; idle();
    #1;
    chk("t6_count0", 32'(bus.count), 32'd0);
    chk("t6_no_write", 32'(bus.write_en), 32'd0);
    chk("t6_tag0", 32'(bus.issue_tag), 32'd0);
    cyc();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      pct = (c < 400) ? 50 : 15;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 60)
        issue(5'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0), 1'($urandom), $urandom);
      if ($urandom_range(0, 99) < pct) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, q.size() - 1);
          cdb(5'(q[k].tag), $urandom, ($urandom_range(0, 3) == 0) ? !q[k].pred : q[k].pred);
        end else begin
          cdb(5'($urandom_range(0, 31)), $urandom, 1'($urandom));
        end
      end
      bus.query1_tag = bus.cdb_valid && $urandom_range(0, 1) == 1 ? bus.cdb_tag : 5'($urandom_range(0, 31));
      bus.query2_tag = (q.size() > 0) ? 5'(q[$urandom_range(0, q.size() - 1)].tag) : 5'($urandom_range(0, 31));
      cyc();
    end
    rst = 0;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
